// File: rtl/vga_sync_receiver.sv
// VGA sink: measures sync timing, locks to the configured mode and
// regenerates active-area pixel coordinates with a qualified rgb stream.
module vga_sync_receiver #(
  parameter int H_disp  = 640,
  parameter int H_front = 16,
  parameter int H_sync  = 96,
  parameter int H_back  = 48,
  parameter int V_disp  = 480,
  parameter int V_front = 10,
  parameter int V_sync  = 2,
  parameter int V_back  = 33,
  parameter int CW      = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          r_in,
  input  logic          g_in,
  input  logic          b_in,
  output logic [31:0]   x,
  output logic [31:0]   y,
  output logic          pix_valid,
  output logic          r_out,
  output logic          g_out,
  output logic          b_out,
  output logic          frame_start,
  output logic          locked,
  output logic [CW-1:0] line_len,
  output logic [CW-1:0] frame_lines,
  output logic [7:0]    err_cnt
);

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } state_t;

  localparam int HT = H_front + H_sync + H_back + H_disp;
  localparam int VT = V_front + V_sync + V_back + V_disp;
  localparam logic [CW:0] H_TOT = (CW+1)'(HT);
  localparam logic [CW:0] V_TOT = (CW+1)'(VT);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] H_LO = CW'(H_sync + H_back);
  localparam logic [CW-1:0] H_HI = CW'(H_sync + H_back + H_disp - 1);
  localparam logic [CW-1:0] V_LO = CW'(V_sync + V_back);
  localparam logic [CW-1:0] V_HI = CW'(V_sync + V_back + V_disp - 1);

  logic          s1_hs_q, s1_hs_d;
  logic          s1_vs_q, s1_vs_d;
  logic [2:0]    s1_rgb_q, s1_rgb_d;
  logic          s2_hs_q, s2_hs_d;
  logic          arm_q, arm_d;
  logic          vs_at_hs_q, vs_at_hs_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic          seen_q, seen_d;
  logic          bad_acc_q, bad_acc_d;
  state_t        state_q, state_d;
  logic [1:0]    good_q, good_d;
  logic          locked_q, locked_d;
  logic [7:0]    err_q, err_d;
  logic [CW-1:0] line_len_q, line_len_d;
  logic [CW-1:0] frame_lines_q, frame_lines_d;
  logic          fs_q, fs_d;
  logic          pv_q, pv_d;
  logic [31:0]   x_q, x_d;
  logic [31:0]   y_q, y_d;
  logic [2:0]    rgb_q, rgb_d;

  logic          hs_fall, vs_fall;
  logic          line_bad, frame_bad, loss, active;
  logic [CW:0]   hlen, vlen;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hs_q       <= 1'b1;
      s1_vs_q       <= 1'b1;
      s1_rgb_q      <= '0;
      s2_hs_q       <= 1'b1;
      arm_q         <= 1'b0;
      vs_at_hs_q    <= 1'b1;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      seen_q        <= 1'b0;
      bad_acc_q     <= 1'b0;
      good_q        <= '0;
      locked_q      <= 1'b0;
      err_q         <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      fs_q          <= 1'b0;
      pv_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      rgb_q         <= '0;
    end else begin
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      s1_rgb_q      <= s1_rgb_d;
      s2_hs_q       <= s2_hs_d;
      arm_q         <= arm_d;
      vs_at_hs_q    <= vs_at_hs_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      seen_q        <= seen_d;
      bad_acc_q     <= bad_acc_d;
      good_q        <= good_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      fs_q          <= fs_d;
      pv_q          <= pv_d;
      x_q           <= x_d;
      y_q           <= y_d;
      rgb_q         <= rgb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEARCH;
    else     state_q <= state_d;
  end

  always_comb begin
    s1_hs_d  = hsync;
    s1_vs_d  = vsync;
    s1_rgb_d = {r_in, g_in, b_in};
    // first sample after reset seeds the history, so a held-low
    // input is never mistaken for a falling edge
    s2_hs_d  = arm_q ? s1_hs_q : hsync;
    arm_d    = 1'b1;

    hs_fall = arm_q & s2_hs_q & ~s1_hs_q;
    vs_fall = hs_fall & ~s1_vs_q & vs_at_hs_q;
    hlen    = {1'b0, hcnt_q} + (CW+1)'(1);
    vlen    = {1'b0, vcnt_q} + (CW+1)'(1);

    line_bad  = hs_fall & seen_q & (hlen != H_TOT);
    frame_bad = (vlen != V_TOT) | bad_acc_q | line_bad;

    if (hs_fall)             hcnt_d = '0;
    else if (hcnt_q == CMAX) hcnt_d = CMAX;
    else                     hcnt_d = hcnt_q + CW'(1);

    vcnt_d = vcnt_q;
    if (vs_fall)                 vcnt_d = '0;
    else if (hs_fall && vcnt_q != CMAX)
      vcnt_d = vcnt_q + CW'(1);

    vs_at_hs_d = hs_fall ? s1_vs_q : vs_at_hs_q;

    line_len_d = line_len_q;
    if (hs_fall && seen_q)
      line_len_d = hlen[CW] ? CMAX : hlen[CW-1:0];
    frame_lines_d = frame_lines_q;
    if (vs_fall)
      frame_lines_d = vlen[CW] ? CMAX : vlen[CW-1:0];

    bad_acc_d = vs_fall ? 1'b0 : (bad_acc_q | line_bad);
    fs_d      = vs_fall;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    loss    = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (vs_fall) begin
          if (frame_bad) begin
            good_d = '0;
          end else if (good_q == 2'd1) begin
            good_d  = 2'd2;
            state_d = LOCKED;
          end else begin
            good_d = good_q + 2'd1;
          end
        end
      end
      LOCKED: begin
        if (line_bad || (vs_fall && frame_bad)) begin
          state_d = SEARCH;
          loss    = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    locked_d = (state_d == LOCKED);
    err_d    = (loss && err_q != 8'hff) ? err_q + 8'd1 : err_q;
    seen_d   = (loss || state_q == LOCKED && state_d == SEARCH)
             ? 1'b0 : (seen_q | hs_fall);
    // position of the pixel currently held in s1
    active = (hcnt_d >= H_LO) && (hcnt_d <= H_HI) &&
             (vcnt_d >= V_LO) && (vcnt_d <= V_HI);
    pv_d   = active & locked_d;
    x_d    = active ? 32'(hcnt_d - H_LO) : x_q;
    y_d    = active ? 32'(vcnt_d - V_LO) : y_q;
    rgb_d  = pv_d ? s1_rgb_q : 3'b000;
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pix_valid   = pv_q;
  assign r_out       = rgb_q[2];
  assign g_out       = rgb_q[1];
  assign b_out       = rgb_q[0];
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a reduced 8x6 timing mode.
module tb_vga_sync_receiver;

  localparam int HD = 4, HF = 1, HS = 2, HB = 1;
  localparam int VD = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hsync = 1'b1, vsync = 1'b1;
  logic          r_in = 1'b0, g_in = 1'b0, b_in = 1'b0;
  logic [31:0]   x, y;
  logic          pix_valid, r_out, g_out, b_out;
  logic          frame_start, locked;
  logic [CW-1:0] line_len, frame_lines;
  logic [7:0]    err_cnt;

  int n_cmp = 0, n_bad = 0;
  int drv_cyc = 0, fstart_cyc = 0, mark_cyc = 0;
  bit mon_en = 0;

  int fs_cnt = 0, pv_cnt = 0, xy_bad = 0, rgb_bad = 0;
  int rise_cyc = -1, fall_cyc = -1, fall_len = -1, fall_fl = -1;
  logic [31:0] first_x = 0, first_y = 0, last_x = 0, last_y = 0;
  logic locked_p = 1'b0;
  logic [2:0] h1 = 3'b0, h2 = 3'b0;

  vga_sync_receiver #(
    .H_disp(HD), .H_front(HF), .H_sync(HS), .H_back(HB),
    .V_disp(VD), .V_front(VF), .V_sync(VS), .V_back(VB),
    .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .x(x), .y(y), .pix_valid(pix_valid),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .frame_start(frame_start), .locked(locked),
    .line_len(line_len), .frame_lines(frame_lines),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    h1 <= {r_in, g_in, b_in};
    h2 <= h1;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      locked_p <= locked;
      if (locked && !locked_p) rise_cyc <= drv_cyc;
      if (!locked && locked_p) begin
        fall_cyc <= drv_cyc;
        fall_len <= int'(line_len);
        fall_fl  <= int'(frame_lines);
      end
      if (frame_start) begin
        fs_cnt <= fs_cnt + 1;
        pv_cnt <= 0;
      end else if (pix_valid) begin
        if (pv_cnt == 0) begin
          first_x <= x;
          first_y <= y;
        end
        last_x <= x;
        last_y <= y;
        pv_cnt <= pv_cnt + 1;
        if (x !== 32'(pv_cnt % HD) || y !== 32'(pv_cnt / HD))
          xy_bad <= xy_bad + 1;
      end
      if (pix_valid ? ({r_out, g_out, b_out} !== h2)
                    : ({r_out, g_out, b_out} !== 3'b000))
        rgb_bad <= rgb_bad + 1;
    end
  end

  task automatic px(input logic hs, input logic vs);
    hsync = hs;
    vsync = vs;
    {r_in, g_in, b_in} = 3'($urandom_range(0, 7));
    @(posedge clk);
    drv_cyc++;
    #1;
  endtask

  task automatic drive_frame(input int nl, input int bl, input int blen);
    for (int l = 0; l < nl; l++) begin
      int len;
      len = (l == bl) ? blen : HT;
      for (int p = 0; p < len; p++) begin
        px(p >= HS, l >= VS);
        if (p == 0 && l == 0) fstart_cyc = drv_cyc;
        if (p == 0 && l == bl + 1) mark_cyc = drv_cyc;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    px(1'b1, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) px(1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    px(1'b0, 1'b0);
    px(1'b0, 1'b0);
    mon_en = 1;
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked got %0b want 0", locked); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_err got %0d want 0", err_cnt); end
    n_cmp++; if (line_len !== '0) begin n_bad++; $display("FAIL rst_line_len got %0d want 0", line_len); end
    n_cmp++; if (frame_lines !== '0) begin n_bad++; $display("FAIL rst_frame_lines got %0d want 0", frame_lines); end
    n_cmp++; if (x !== 32'd0 || y !== 32'd0) begin n_bad++; $display("FAIL rst_xy got %0d,%0d want 0,0", x, y); end
    n_cmp++; if ({pix_valid, frame_start, r_out, g_out, b_out} !== 5'b0) begin
      n_bad++; $display("FAIL rst_flags got %b want 00000", {pix_valid, frame_start, r_out, g_out, b_out}); end
    rst = 1'b0;
  endtask

  task automatic test_lock();
    int fs0, fs_lock;
    do_reset();
    fs0 = fs_cnt;
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    fs_lock = fstart_cyc;
    drive_frame(VT, -1, 0);
    n_cmp++; if (rise_cyc !== fs_lock + 1) begin n_bad++; $display("FAIL lock_rise got %0d want %0d", rise_cyc, fs_lock + 1); end
    n_cmp++; if (fs_cnt - fs0 !== 4) begin n_bad++; $display("FAIL lock_fs_cnt got %0d want 4", fs_cnt - fs0); end
    n_cmp++; if (line_len !== CW'(HT)) begin n_bad++; $display("FAIL lock_line_len got %0d want %0d", line_len, HT); end
    n_cmp++; if (frame_lines !== CW'(VT)) begin n_bad++; $display("FAIL lock_frame_lines got %0d want %0d", frame_lines, VT); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL lock_err got %0d want 0", err_cnt); end
    n_cmp++; if (pv_cnt !== HD * VD) begin n_bad++; $display("FAIL pv_count got %0d want %0d", pv_cnt, HD * VD); end
    n_cmp++; if (first_x !== 0 || first_y !== 0) begin n_bad++; $display("FAIL first_xy got %0d,%0d want 0,0", first_x, first_y); end
    n_cmp++; if (last_x !== HD - 1 || last_y !== VD - 1) begin
      n_bad++; $display("FAIL last_xy got %0d,%0d want %0d,%0d", last_x, last_y, HD - 1, VD - 1); end
    n_cmp++; if (xy_bad !== 0) begin n_bad++; $display("FAIL raster_xy got %0d bad want 0", xy_bad); end
    n_cmp++; if (rgb_bad !== 0) begin n_bad++; $display("FAIL rgb_delay got %0d bad want 0", rgb_bad); end
  endtask

  task automatic test_short_line();
    drive_frame(VT, 2, HT - 1);
    n_cmp++; if (fall_cyc !== mark_cyc + 1) begin n_bad++; $display("FAIL sl_fall got %0d want %0d", fall_cyc, mark_cyc + 1); end
    n_cmp++; if (fall_len !== HT - 1) begin n_bad++; $display("FAIL sl_line_len got %0d want %0d", fall_len, HT - 1); end
    n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL sl_err got %0d want 1", err_cnt); end
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL sl_early_lock got %0b want 0", locked); end
    drive_frame(VT, -1, 0);
    n_cmp++; if (rise_cyc !== fstart_cyc + 1) begin n_bad++; $display("FAIL sl_relock got %0d want %0d", rise_cyc, fstart_cyc + 1); end
  endtask

  task automatic test_short_frame();
    drive_frame(VT - 1, -1, 0);
    drive_frame(VT, -1, 0);
    n_cmp++; if (fall_cyc !== fstart_cyc + 1) begin n_bad++; $display("FAIL sf_fall got %0d want %0d", fall_cyc, fstart_cyc + 1); end
    n_cmp++; if (fall_fl !== VT - 1) begin n_bad++; $display("FAIL sf_frame_lines got %0d want %0d", fall_fl, VT - 1); end
    n_cmp++; if (err_cnt !== 8'd2) begin n_bad++; $display("FAIL sf_err got %0d want 2", err_cnt); end
    drive_frame(VT, -1, 0);
    drive_frame(VT - 1, -1, 0);
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL acq_good_reset got %0b want 0", locked); end
    drive_frame(VT, -1, 0);
    n_cmp++; if (rise_cyc !== fstart_cyc + 1) begin n_bad++; $display("FAIL acq_relock got %0d want %0d", rise_cyc, fstart_cyc + 1); end
  endtask

  task automatic test_stuck_hsync();
    drive_frame(VT, 2, HT + 20);
    n_cmp++; if (fall_cyc !== mark_cyc + 1) begin n_bad++; $display("FAIL stall_fall got %0d want %0d", fall_cyc, mark_cyc + 1); end
    n_cmp++; if (fall_len !== HT + 20) begin n_bad++; $display("FAIL stall_len got %0d want %0d", fall_len, HT + 20); end
    n_cmp++; if (err_cnt !== 8'd3) begin n_bad++; $display("FAIL stall_err got %0d want 3", err_cnt); end
  endtask

  task automatic test_reset_mid();
    int fs0;
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    for (int l = 0; l < 3; l++)
      for (int p = 0; p < ((l == 2) ? 6 : HT); p++)
        px(p >= HS, l >= VS);
    n_cmp++; if ({locked, pix_valid} !== 2'b11) begin n_bad++; $display("FAIL mid_pre got %b want 11", {locked, pix_valid}); end
    n_cmp++; if (x !== 32'd1 || y !== 32'd0) begin n_bad++; $display("FAIL mid_pre_xy got %0d,%0d want 1,0", x, y); end
    rst = 1'b1;
    px(1'b1, 1'b1);
    n_cmp++; if ({locked, pix_valid, frame_start} !== 3'b000) begin
      n_bad++; $display("FAIL mid_rst_flags got %b want 000", {locked, pix_valid, frame_start}); end
    n_cmp++; if (err_cnt !== 8'd0 || line_len !== '0 || frame_lines !== '0) begin
      n_bad++; $display("FAIL mid_rst_cnt got %0d/%0d/%0d want 0/0/0", err_cnt, line_len, frame_lines); end
    n_cmp++; if (x !== 32'd0 || y !== 32'd0) begin n_bad++; $display("FAIL mid_rst_xy got %0d,%0d want 0,0", x, y); end
    px(1'b0, 1'b0);
    rst = 1'b0;
    fs0 = fs_cnt;
    for (int i = 0; i < 30; i++) px(1'b0, 1'b0);
    n_cmp++; if (fs_cnt !== fs0 || frame_lines !== '0) begin
      n_bad++; $display("FAIL stuck_low_edge got fs+%0d fl=%0d want fs+0 fl=0", fs_cnt - fs0, frame_lines); end
    n_cmp++; if (line_len !== '0 || locked !== 1'b0) begin
      n_bad++; $display("FAIL stuck_low_len got %0d/%0b want 0/0", line_len, locked); end
  endtask

  task automatic test_err_saturate();
    do_reset();
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    for (int i = 0; i < 255; i++) begin
      drive_frame(VT, 1, HT - 1);
      drive_frame(VT, -1, 0);
      drive_frame(VT, -1, 0);
    end
    n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL err_255 got %0d want 255", err_cnt); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL err_loop_state got %0b want 0", locked); end
    drive_frame(VT, 1, HT - 1);
    n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL err_sat got %0d want 255", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_short_line();
    test_short_frame();
    test_stuck_hsync();
    test_reset_mid();
    test_err_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Sink end of the VGA link: samples hsync/vsync/RGB from a timing generator plus pattern source.
- Measures line and frame lengths and locks when they match the configured mode.
- Once locked, regenerates pixel coordinates with a qualified pixel stream.
- Used as a loop-back checker in simulation, and as the front end for frame capture and compare logic.

Parameters:
- H_disp, 640, active pixels per line
- H_front, 16, horizontal front porch (clocks)
- H_sync, 96, hsync pulse width (clocks)
- H_back, 48, horizontal back porch (clocks)
- V_disp, 480, active lines per frame
- V_front, 10, vertical front porch (lines)
- V_sync, 2, vsync pulse width (lines)
- V_back, 33, vertical back porch (lines)
- CW, 12, width of internal h/v counters

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- hsync  in  1  horizontal sync, active-low
- vsync  in  1  vertical sync, active-low
- r_in, g_in, b_in  in  1 each  pixel colour
- x  out  32  active-area column of the current output pixel
- y  out  32  active-area row of the current output pixel
- pix_valid  out  1  x/y/rgb valid (active area, locked only)
- r_out, g_out, b_out  out  1 each  registered colour
- frame_start  out  1  one-clock pulse at each vsync falling edge
- locked  out  1  timing lock status
- line_len  out  CW  length of the last completed line (clocks)
- frame_lines  out  CW  line count of the last completed frame
- err_cnt  out  8  saturating count of lock losses

Behaviour:
- Clock and reset:
  - Single clock domain; inputs are synchronous to clk, so there is no synchroniser.
  - Stage 1 registers hsync, vsync and rgb as s1. Stage 2 holds the previous s1 values for edge detection.
- Reset (rst=1 at a clk edge):
  - All outputs 0 (x=0, y=0, line_len=0, frame_lines=0, err_cnt=0, locked=0).
  - FSM goes to SEARCH; counters clear; sync history is set to 1 (idle), so a low input right after reset is not an edge.
- hsync edge (hs_fall) = s1.hsync==0 and previous==1.
  - Sets hcnt=0; otherwise hcnt increments, saturating at 2^CW-1.
  - In the same cycle: line_len <= hcnt+1 (old hcnt), provided at least one earlier hs_fall has been seen since reset or SEARCH entry.
- Line counter vcnt updates at hs_fall:
  - If s1.vsync==0 and vsync was 1 at the previous hs_fall (vs_fall): vcnt=0, frame_lines <= old vcnt+1, frame_start pulses.
  - Otherwise vcnt increments, saturating.
  - vsync changing without a coincident hs_fall is only recorded; it acts at the next hs_fall.
- Totals: H_total = H_front+H_sync+H_back+H_disp (800). V_total likewise (525).
- A line is bad if the measured line_len != H_total. A frame is bad if the measured frame_lines != V_total, or if any line in it was bad.
- Lock FSM:
  - SEARCH: at vs_fall go to ACQUIRE with good=0. Length checks are ignored.
  - ACQUIRE: at each vs_fall, a good frame increments good, a bad frame sets good=0. At good==2 go to LOCKED; locked rises in the same cycle as that frame_start.
  - LOCKED: any bad line, or bad frame at vs_fall, goes to SEARCH, clears locked, and increments err_cnt (saturating at 255).
  - Loss detection is immediate, on the hs_fall or vs_fall that ends the bad line or frame.
- Active area:
  - hcnt in [H_sync+H_back, H_sync+H_back+H_disp-1] and vcnt in [V_sync+V_back, V_sync+V_back+V_disp-1].
  - x = hcnt-(H_sync+H_back), y = vcnt-(V_sync+V_back), zero-extended to 32 bits.
- Output stage:
  - Registers pix_valid (active area AND locked), x, y and rgb from s1.
  - Latency: an input sampled at edge k appears on the outputs after edge k+1.
  - Outside the active area: x and y hold their last values, pix_valid=0, rgb forced to 0.
- No hsync (stuck input): hcnt saturates and no lines complete. locked holds until the next hs_fall measures a bad length.
- hs_fall and vs_fall in the same cycle: apply the line check first, then the frame check. At most one err_cnt increment per cycle.

Test Plan:
- Reset, then nominal 640x480 timing (800x525): locked rises at the 3rd vs_fall. line_len=800, frame_lines=525, err_cnt=0.
- Locked frame: exactly 307200 pix_valid cycles; first valid has x=0, y=0; last has x=639, y=479. Output rgb equals input rgb delayed 2 clocks.
- One 799-clock line while locked: locked drops at that hs_fall, line_len=799, err_cnt=1. Relock at the 3rd following vs_fall.
- One frame with 524 lines: locked drops at its vs_fall with frame_lines=524. In ACQUIRE, good resets to 0.
- Reset asserted mid-line while locked: the next cycle shows all outputs 0 and the FSM in SEARCH. After release, a stuck-low hsync produces no hs_fall.
- Force 256 lock losses: err_cnt saturates at 255 and does not wrap.
